reg_to_apb: RTL and testbench

- Register-bus target (responder) that converts each register-bus request into one APB4 transfer as APB master (initiator).
- Lets blocks that master the register bus reach APB peripherals; this is the inverse of the existing APB-to-register-bus bridge.
- APB outputs are registered. The register-bus response is registered and presented for exactly one cycle.
- An optional watchdog aborts transfers where the APB slave never asserts pready.

---
 rtl/reg_to_apb.sv | 129 ++++++++++++
 tb/tb_reg_to_apb.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_to_apb.sv
// Register-bus target that issues one APB4 transfer per request as APB initiator.
// APB outputs and the one-cycle register-bus response are fully registered.
module reg_to_apb #(
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned DataWidth     = 32,
    parameter logic [2:0]  Pprot         = 3'b000,
    parameter int unsigned TimeoutCycles = 0,
    localparam int unsigned StrbWidth    = DataWidth / 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 reg_valid_i,
    input  logic                 reg_write_i,
    input  logic [AddrWidth-1:0] reg_addr_i,
    input  logic [DataWidth-1:0] reg_wdata_i,
    input  logic [StrbWidth-1:0] reg_wstrb_i,
    output logic                 reg_ready_o,
    output logic [DataWidth-1:0] reg_rdata_o,
    output logic                 reg_error_o,
    output logic                 psel_o,
    output logic                 penable_o,
    output logic                 pwrite_o,
    output logic [AddrWidth-1:0] paddr_o,
    output logic [DataWidth-1:0] pwdata_o,
    output logic [StrbWidth-1:0] pstrb_o,
    output logic [2:0]           pprot_o,
    input  logic                 pready_i,
    input  logic [DataWidth-1:0] prdata_i,
    input  logic                 pslverr_i
);

    localparam bit          TimeoutEn = (TimeoutCycles != 0);
    localparam int unsigned CntWidth  = TimeoutEn ? 16 : 1;
    localparam logic [CntWidth-1:0] CntLast =
        TimeoutEn ? CntWidth'(TimeoutCycles - 1) : '0;

    if (DataWidth % 8 != 0) begin : gen_bad_data_width
        $error("reg_to_apb: DataWidth must be a multiple of 8");
    end
    if (TimeoutCycles >= 65536) begin : gen_bad_timeout
        $error("reg_to_apb: TimeoutCycles must be below 2^16");
    end

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

    state_e                state_q;
    logic [CntWidth-1:0]   cnt_q;
    logic                  psel_q;
    logic                  penable_q;
    logic                  pwrite_q;
    logic [AddrWidth-1:0]  paddr_q;
    logic [DataWidth-1:0]  pwdata_q;
    logic [StrbWidth-1:0]  pstrb_q;
    logic                  reg_ready_q;
    logic [DataWidth-1:0]  reg_rdata_q;
    logic                  reg_error_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            reg_ready_q <= 1'b0;
            reg_rdata_q <= '0;
            reg_error_q <= 1'b0;
        end else begin
            reg_ready_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (reg_valid_i) begin
                        psel_q   <= 1'b1;
                        pwrite_q <= reg_write_i;
                        paddr_q  <= reg_addr_i;
                        pwdata_q <= reg_wdata_i;
                        pstrb_q  <= reg_write_i ? reg_wstrb_i : '0;
                        state_q  <= StSetup;
                    end
                end
                StSetup: begin
                    penable_q <= 1'b1;
                    cnt_q     <= '0;
                    state_q   <= StAccess;
                end
                StAccess: begin
                    // pready wins over the watchdog when both fire in one cycle
                    if (pready_i) begin
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        reg_ready_q <= 1'b1;
                        reg_rdata_q <= pwrite_q ? '0 : prdata_i;
                        reg_error_q <= pslverr_i;
                        state_q     <= StResp;
                    end else if (TimeoutEn && (cnt_q == CntLast)) begin
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        reg_ready_q <= 1'b1;
                        reg_rdata_q <= '0;
                        reg_error_q <= 1'b1;
                        state_q     <= StResp;
                    end else if (cnt_q != {CntWidth{1'b1}}) begin
                        cnt_q <= cnt_q + CntWidth'(1);
                    end
                end
                StResp: begin
                    // reg_valid_i here still belongs to the request being acknowledged
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign reg_ready_o = reg_ready_q;
    assign reg_rdata_o = reg_rdata_q;
    assign reg_error_o = reg_error_q;
    assign psel_o      = psel_q;
    assign penable_o   = penable_q;
    assign pwrite_o    = pwrite_q;
    assign paddr_o     = paddr_q;
    assign pwdata_o    = pwdata_q;
    assign pstrb_o     = pstrb_q;
    assign pprot_o     = Pprot;

endmodule

// File: tb/tb_reg_to_apb.sv
// Directed bench for reg_to_apb: cycle-accurate checks of APB sequencing and responses.
module tb_reg_to_apb;

    logic        clk_i;
    logic        rst_ni;
    logic        reg_valid_i;
    logic        reg_write_i;
    logic [31:0] reg_addr_i;
    logic [31:0] reg_wdata_i;
    logic [3:0]  reg_wstrb_i;
    logic        reg_ready_o;
    logic [31:0] reg_rdata_o;
    logic        reg_error_o;
    logic        psel_o;
    logic        penable_o;
    logic        pwrite_o;
    logic [31:0] paddr_o;
    logic [31:0] pwdata_o;
    logic [3:0]  pstrb_o;
    logic [2:0]  pprot_o;
    logic        pready_i;
    logic [31:0] prdata_i;
    logic        pslverr_i;

    int checks = 0;
    int errors = 0;

    reg_to_apb #(
        .AddrWidth     (32),
        .DataWidth     (32),
        .Pprot         (3'b010),
        .TimeoutCycles (8)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .reg_valid_i (reg_valid_i),
        .reg_write_i (reg_write_i),
        .reg_addr_i  (reg_addr_i),
        .reg_wdata_i (reg_wdata_i),
        .reg_wstrb_i (reg_wstrb_i),
        .reg_ready_o (reg_ready_o),
        .reg_rdata_o (reg_rdata_o),
        .reg_error_o (reg_error_o),
        .psel_o      (psel_o),
        .penable_o   (penable_o),
        .pwrite_o    (pwrite_o),
        .paddr_o     (paddr_o),
        .pwdata_o    (pwdata_o),
        .pstrb_o     (pstrb_o),
        .pprot_o     (pprot_o),
        .pready_i    (pready_i),
        .prdata_i    (prdata_i),
        .pslverr_i   (pslverr_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb);
        reg_valid_i = 1'b1;
        reg_write_i = wr;
        reg_addr_i  = addr;
        reg_wdata_i = wdata;
        reg_wstrb_i = strb;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        reg_valid_i = 1'b0; reg_write_i = 1'b0; reg_addr_i = '0; reg_wdata_i = '0;
        reg_wstrb_i = '0; pready_i = 1'b0; prdata_i = '0; pslverr_i = 1'b0;
        #2;
        checks++; if (pprot_o !== 3'b010) begin errors++; $display("FAIL rst_pprot: got %h exp 2", pprot_o); end
        tick(); tick();
        checks++; if ({psel_o, penable_o, pwrite_o, reg_ready_o, reg_error_o} !== 5'b0) begin
            errors++; $display("FAIL rst_ctrl: got %b exp 00000", {psel_o, penable_o, pwrite_o, reg_ready_o, reg_error_o}); end
        checks++; if ({paddr_o, pwdata_o, pstrb_o, reg_rdata_o} !== 100'b0) begin
            errors++; $display("FAIL rst_data: got %h %h %h %h exp 0", paddr_o, pwdata_o, pstrb_o, reg_rdata_o); end
        rst_ni = 1'b1;
        tick();
        checks++; if (psel_o !== 1'b0) begin errors++; $display("FAIL rst_idle_psel: got %b exp 0", psel_o); end
        checks++; if (pprot_o !== 3'b010) begin errors++; $display("FAIL post_rst_pprot: got %h exp 2", pprot_o); end
    endtask

    task automatic test_write_zero_wait();
        req(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF);
        pready_i = 1'b1; pslverr_i = 1'b0;
        tick(); // cycle 1
        checks++; if ({psel_o, penable_o} !== 2'b10) begin errors++; $display("FAIL wr_c1_sel_en: got %b exp 10", {psel_o, penable_o}); end
        checks++; if (pwrite_o !== 1'b1 || pstrb_o !== 4'hF) begin errors++; $display("FAIL wr_c1_dir_strb: got %b %h exp 1 f", pwrite_o, pstrb_o); end
        checks++; if (paddr_o !== 32'h0000_1004 || pwdata_o !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL wr_c1_addr_data: got %h %h exp 00001004 deadbeef", paddr_o, pwdata_o); end
        tick(); // cycle 2
        checks++; if ({psel_o, penable_o, reg_ready_o} !== 3'b110) begin errors++; $display("FAIL wr_c2_access: got %b exp 110", {psel_o, penable_o, reg_ready_o}); end
        tick(); // cycle 3
        checks++; if ({psel_o, penable_o, reg_ready_o, reg_error_o} !== 4'b0010) begin
            errors++; $display("FAIL wr_c3_resp: got %b exp 0010", {psel_o, penable_o, reg_ready_o, reg_error_o}); end
        checks++; if (reg_rdata_o !== 32'h0) begin errors++; $display("FAIL wr_c3_rdata: got %h exp 0", reg_rdata_o); end
        reg_valid_i = 1'b0;
        tick(); // cycle 4
        checks++; if ({psel_o, reg_ready_o} !== 2'b00) begin errors++; $display("FAIL wr_c4_idle: got %b exp 00", {psel_o, reg_ready_o}); end
    endtask

    task automatic test_read_wait();
        req(1'b0, 32'h0000_0020, 32'h5555_5555, 4'hF);
        pready_i = 1'b0;
        tick(); // cycle 1
        checks++; if ({psel_o, penable_o, pwrite_o} !== 3'b100 || pstrb_o !== 4'h0) begin
            errors++; $display("FAIL rd_c1_setup: got %b %h exp 100 0", {psel_o, penable_o, pwrite_o}, pstrb_o); end
        for (int c = 2; c <= 4; c++) begin
            tick();
            checks++; if ({psel_o, penable_o, reg_ready_o} !== 3'b110 || paddr_o !== 32'h20) begin
                errors++; $display("FAIL rd_wait_c%0d: got %b %h exp 110 20", c, {psel_o, penable_o, reg_ready_o}, paddr_o); end
        end
        tick(); // cycle 5: last ACCESS cycle
        pready_i = 1'b1; prdata_i = 32'h1234_5678;
        checks++; if ({psel_o, penable_o, reg_ready_o} !== 3'b110) begin errors++; $display("FAIL rd_c5_access: got %b exp 110", {psel_o, penable_o, reg_ready_o}); end
        tick(); // cycle 6
        checks++; if ({psel_o, penable_o, reg_ready_o, reg_error_o} !== 4'b0010) begin
            errors++; $display("FAIL rd_c6_resp: got %b exp 0010", {psel_o, penable_o, reg_ready_o, reg_error_o}); end
        checks++; if (reg_rdata_o !== 32'h1234_5678) begin errors++; $display("FAIL rd_c6_rdata: got %h exp 12345678", reg_rdata_o); end
        reg_valid_i = 1'b0; pready_i = 1'b0; prdata_i = 32'hFFFF_FFFF;
        tick(); // cycle 7: captured data holds
        checks++; if (reg_ready_o !== 1'b0 || reg_rdata_o !== 32'h1234_5678) begin
            errors++; $display("FAIL rd_c7_hold: got %b %h exp 0 12345678", reg_ready_o, reg_rdata_o); end
    endtask

    task automatic test_timeout();
        req(1'b0, 32'h0000_0040, 32'h0, 4'h0);
        pready_i = 1'b0;
        tick(); // cycle 1
        for (int c = 2; c <= 9; c++) begin
            tick();
            checks++; if ({psel_o, penable_o, reg_ready_o} !== 3'b110) begin
                errors++; $display("FAIL to_access_c%0d: got %b exp 110", c, {psel_o, penable_o, reg_ready_o}); end
        end
        tick(); // cycle 10
        checks++; if ({psel_o, penable_o, reg_ready_o, reg_error_o} !== 4'b0011) begin
            errors++; $display("FAIL to_resp: got %b exp 0011", {psel_o, penable_o, reg_ready_o, reg_error_o}); end
        checks++; if (reg_rdata_o !== 32'h0) begin errors++; $display("FAIL to_rdata: got %h exp 0", reg_rdata_o); end
        reg_valid_i = 1'b0;
        tick();
    endtask

    task automatic test_timeout_edge();
        req(1'b0, 32'h0000_0044, 32'h0, 4'h0);
        pready_i = 1'b0;
        tick(); // cycle 1
        for (int c = 2; c <= 9; c++) begin
            tick();
            if (c == 9) begin pready_i = 1'b1; prdata_i = 32'hCAFE_0001; end
        end
        tick(); // cycle 10
        checks++; if ({reg_ready_o, reg_error_o} !== 2'b10 || reg_rdata_o !== 32'hCAFE_0001) begin
            errors++; $display("FAIL to_edge_resp: got %b %h exp 10 cafe0001", {reg_ready_o, reg_error_o}, reg_rdata_o); end
        reg_valid_i = 1'b0; pready_i = 1'b0;
        tick();
    endtask

    task automatic test_slave_error();
        req(1'b1, 32'h0000_0008, 32'h0BAD_0BAD, 4'h3);
        pready_i = 1'b1; pslverr_i = 1'b1;
        tick(); tick(); tick(); // cycle 3
        checks++; if ({reg_ready_o, reg_error_o} !== 2'b11) begin errors++; $display("FAIL err_resp: got %b exp 11", {reg_ready_o, reg_error_o}); end
        reg_valid_i = 1'b0; pslverr_i = 1'b0;
        tick();
        checks++; if ({reg_ready_o, reg_error_o} !== 2'b01) begin errors++; $display("FAIL err_hold: got %b exp 01", {reg_ready_o, reg_error_o}); end
        req(1'b1, 32'h0000_000C, 32'h1, 4'h1);
        tick(); tick(); tick();
        checks++; if ({reg_ready_o, reg_error_o} !== 2'b10) begin errors++; $display("FAIL err_clear: got %b exp 10", {reg_ready_o, reg_error_o}); end
        reg_valid_i = 1'b0; pready_i = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        req(1'b1, 32'h0000_0000, 32'h1111_1111, 4'hF);
        pready_i = 1'b1;
        tick(); // cycle 1
        checks++; if (psel_o !== 1'b1 || paddr_o !== 32'h0) begin errors++; $display("FAIL b2b_c1: got %b %h exp 1 0", psel_o, paddr_o); end
        tick(); tick(); // cycle 3: response, request still held
        checks++; if (reg_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_c3_ready: got %b exp 1", reg_ready_o); end
        tick(); // cycle 4: must be idle, no re-issue of the acknowledged request
        checks++; if ({psel_o, penable_o, reg_ready_o} !== 3'b000) begin
            errors++; $display("FAIL b2b_c4_idle: got %b exp 000", {psel_o, penable_o, reg_ready_o}); end
        req(1'b1, 32'h0000_0004, 32'h2222_2222, 4'hF);
        tick(); // cycle 5
        checks++; if ({psel_o, penable_o} !== 2'b10 || paddr_o !== 32'h4 || pwdata_o !== 32'h2222_2222) begin
            errors++; $display("FAIL b2b_c5_setup: got %b %h %h exp 10 4 22222222", {psel_o, penable_o}, paddr_o, pwdata_o); end
        tick(); tick(); // cycle 7
        checks++; if (reg_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_c7_ready: got %b exp 1", reg_ready_o); end
        reg_valid_i = 1'b0;
        tick(); tick(); // cycle 9
        checks++; if ({psel_o, reg_ready_o} !== 2'b00) begin errors++; $display("FAIL b2b_c9_quiet: got %b exp 00", {psel_o, reg_ready_o}); end
        pready_i = 1'b0;
    endtask

    task automatic test_reset_mid_access();
        req(1'b0, 32'h0000_0080, 32'h0, 4'h0);
        pready_i = 1'b0;
        tick(); tick(); // cycle 2
        checks++; if (penable_o !== 1'b1) begin errors++; $display("FAIL rstm_access: got %b exp 1", penable_o); end
        #2;
        rst_ni = 1'b0; reg_valid_i = 1'b0;
        #1;
        checks++; if ({psel_o, penable_o, reg_ready_o} !== 3'b000) begin
            errors++; $display("FAIL rstm_async: got %b exp 000", {psel_o, penable_o, reg_ready_o}); end
        @(posedge clk_i);
        #3;
        rst_ni = 1'b1;
        tick();
        checks++; if ({psel_o, penable_o, reg_ready_o} !== 3'b000) begin
            errors++; $display("FAIL rstm_idle: got %b exp 000", {psel_o, penable_o, reg_ready_o}); end
        req(1'b0, 32'h0000_0084, 32'h0, 4'hF);
        pready_i = 1'b1; prdata_i = 32'hA5A5_A5A5;
        tick();
        checks++; if (psel_o !== 1'b1 || paddr_o !== 32'h84) begin errors++; $display("FAIL rstm_setup: got %b %h exp 1 84", psel_o, paddr_o); end
        tick(); tick();
        checks++; if ({reg_ready_o, reg_error_o} !== 2'b10 || reg_rdata_o !== 32'hA5A5_A5A5) begin
            errors++; $display("FAIL rstm_read: got %b %h exp 10 a5a5a5a5", {reg_ready_o, reg_error_o}, reg_rdata_o); end
        reg_valid_i = 1'b0; pready_i = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_wait();
        test_timeout();
        test_timeout_edge();
        test_slave_error();
        test_back_to_back();
        test_reset_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL sim_timeout: got no completion exp completion");
        $fatal(1, "bench time limit");
    end

endmodule
